// File: rtl/alert_pkg.sv
// alert_pkg: shared types and constants for the alert handler escalation path
package alert_pkg;

    localparam int N_PHASES = 4;
    localparam int PhaseDw  = 2;
    localparam int EscCntDw = 32;

    typedef enum logic [2:0] {
        Idle     = 3'd0,
        Timeout  = 3'd1,
        FsmError = 3'd2,
        Terminal = 3'd3,
        Phase0   = 3'd4,
        Phase1   = 3'd5,
        Phase2   = 3'd6,
        Phase3   = 3'd7
    } cstate_e;

    // Phase states occupy the upper half of the encoding, so the phase index is the low bits.
    function automatic cstate_e phase_state(input logic [PhaseDw-1:0] k);
        return cstate_e'({1'b1, k});
    endfunction

endpackage

// File: rtl/alert_handler_esc_timer_if.sv
// alert_handler_esc_timer_if: configuration, trigger and escalation signals of one alert class
interface alert_handler_esc_timer_if #(
    parameter int EscCntDw = alert_pkg::EscCntDw,
    parameter int NEscSev  = 4
);

    logic                                                 en_i;
    logic                                                 clr_i;
    logic                                                 timeout_en_i;
    logic                                                 accu_trig_i;
    logic                                                 accu_fail_i;
    logic [EscCntDw-1:0]                                  timeout_cyc_i;
    logic [alert_pkg::PhaseDw-1:0]                        crashdump_phase_i;
    logic [NEscSev-1:0]                                   esc_en_i;
    logic [NEscSev-1:0][alert_pkg::PhaseDw-1:0]           esc_map_i;
    logic [alert_pkg::N_PHASES-1:0][EscCntDw-1:0]         phase_cyc_i;
    logic                                                 esc_trig_o;
    logic [NEscSev-1:0]                                   esc_sig_req_o;
    logic                                                 latch_crashdump_o;
    logic [EscCntDw-1:0]                                  esc_cnt_o;
    alert_pkg::cstate_e                                   esc_state_o;

    modport master (
        output en_i, clr_i, timeout_en_i, accu_trig_i, accu_fail_i, timeout_cyc_i,
               crashdump_phase_i, esc_en_i, esc_map_i, phase_cyc_i,
        input  esc_trig_o, esc_sig_req_o, latch_crashdump_o, esc_cnt_o, esc_state_o
    );

    modport slave (
        input  en_i, clr_i, timeout_en_i, accu_trig_i, accu_fail_i, timeout_cyc_i,
               crashdump_phase_i, esc_en_i, esc_map_i, phase_cyc_i,
        output esc_trig_o, esc_sig_req_o, latch_crashdump_o, esc_cnt_o, esc_state_o
    );

endinterface

// File: rtl/alert_handler_esc_cnt.sv
// alert_handler_esc_cnt: saturating cycle counter with synchronous clear
module alert_handler_esc_cnt #(
    parameter int Dw = alert_pkg::EscCntDw
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [Dw-1:0] cnt_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_o <= '0;
        else if (clr_i)
            cnt_o <= '0;
        else if (inc_i && cnt_o != '1)
            cnt_o <= cnt_o + Dw'(1);
    end

endmodule

// File: rtl/alert_handler_esc_timer.sv
// alert_handler_esc_timer: per-class interrupt timeout and four-phase escalation sequencer
module alert_handler_esc_timer #(
    parameter int EscCntDw = alert_pkg::EscCntDw,
    parameter int NEscSev  = 4
) (
    input logic                       clk_i,
    input logic                       rst_i,
    alert_handler_esc_timer_if.slave  bus
);

    alert_pkg::cstate_e            state, state_d;
    logic [EscCntDw-1:0]           cnt;
    logic [EscCntDw:0]             cnt_p1;
    logic [alert_pkg::PhaseDw-1:0] k;
    logic [NEscSev-1:0]            req;
    logic                          cnt_clr, cnt_inc, start;

    assign start  = bus.en_i & bus.accu_trig_i;
    assign k      = state[1:0];
    // One extra bit so cnt+1 cannot wrap when cnt is already saturated.
    assign cnt_p1 = {1'b0, cnt} + (EscCntDw+1)'(1);

    always_comb begin
        state_d = state;
        cnt_clr = 1'b1;
        cnt_inc = 1'b0;
        case (state)
            alert_pkg::Idle: begin
                if (bus.clr_i)
                    state_d = alert_pkg::Idle;
                else if (start)
                    state_d = alert_pkg::Phase0;
                else if (bus.en_i && bus.timeout_en_i && bus.timeout_cyc_i != '0)
                    state_d = alert_pkg::Timeout;
            end
            alert_pkg::Timeout: begin
                if (bus.clr_i)
                    state_d = alert_pkg::Idle;
                else if (start || cnt_p1 >= {1'b0, bus.timeout_cyc_i})
                    state_d = alert_pkg::Phase0;
                else if (!bus.timeout_en_i)
                    state_d = alert_pkg::Idle;
                else begin
                    cnt_clr = 1'b0;
                    cnt_inc = 1'b1;
                end
            end
            alert_pkg::Phase0, alert_pkg::Phase1, alert_pkg::Phase2, alert_pkg::Phase3: begin
                if (bus.clr_i)
                    state_d = alert_pkg::Idle;
                else if (cnt < bus.phase_cyc_i[k]) begin
                    cnt_clr = 1'b0;
                    cnt_inc = 1'b1;
                end else
                    state_d = (state == alert_pkg::Phase3) ? alert_pkg::Terminal
                                                           : alert_pkg::phase_state(k + 2'd1);
            end
            alert_pkg::Terminal: begin
                if (bus.clr_i)
                    state_d = alert_pkg::Idle;
            end
            default: state_d = alert_pkg::FsmError;
        endcase
        if (bus.accu_fail_i) begin
            state_d = alert_pkg::FsmError;
            cnt_inc = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= alert_pkg::Idle;
        else
            state <= state_d;
    end

    alert_handler_esc_cnt #(.Dw(EscCntDw)) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .cnt_o (cnt)
    );

    // Requests follow the registered state; FsmError forces every severity on.
    always_comb begin
        req = '0;
        for (int s = 0; s < NEscSev; s++)
            req[s] = (state == alert_pkg::FsmError) ||
                     (state[2] && bus.esc_en_i[s] && bus.esc_map_i[s] == k);
    end

    assign bus.esc_sig_req_o     = req;
    assign bus.esc_state_o       = state;
    assign bus.esc_cnt_o         = cnt;
    assign bus.esc_trig_o        = (state == alert_pkg::Idle || state == alert_pkg::Timeout) &&
                                   state_d == alert_pkg::Phase0;
    assign bus.latch_crashdump_o = state_d == alert_pkg::phase_state(bus.crashdump_phase_i) &&
                                   state != state_d;

    a_trig_gated: assert property (@(posedge clk_i) disable iff (rst_i)
        (state == alert_pkg::Idle && !bus.en_i) |-> !bus.esc_trig_o);

    a_err_sticky: assert property (@(posedge clk_i) disable iff (rst_i)
        state == alert_pkg::FsmError |=> state == alert_pkg::FsmError);

    for (genvar g = 0; g < NEscSev; g++) begin : g_req_chk
        a_req_map: assert property (@(posedge clk_i) disable iff (rst_i)
            (state[2] && bus.esc_sig_req_o[g]) |-> (bus.esc_en_i[g] && bus.esc_map_i[g] == k));
    end

endmodule

// File: doc/alert_handler_esc_timer.md
# alert_handler_esc_timer

Per-class escalation sequencer that consumes the trigger and integrity outputs of the alert accumulator. It runs the interrupt-timeout countdown, then steps through four timed escalation phases, driving the escalation-severity request lines mapped to each phase. It sits between each class accumulator and the escalation senders. It is the downstream end of the accumulator's `accu_trig`/`accu_fail` interface.

## Interface
- `EscCntDw`, default 32: width of cycle counter and all cycle thresholds.
- `NEscSev`, default 4: number of escalation severity outputs.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `en_i`  in  1  class enable; gates all new escalation starts.
- `clr_i`  in  1  clear; aborts timeout or escalation back to Idle.
- `timeout_en_i`  in  1  class interrupt pending; arms the timeout counter.
- `accu_trig_i`  in  1  accumulator threshold trigger.
- `accu_fail_i`  in  1  accumulator tandem-counter mismatch.
- `timeout_cyc_i`  in  EscCntDw  timeout length; 0 disables timeout.
- `crashdump_phase_i`  in  2  phase whose entry latches crashdump.
- `esc_en_i`  in  NEscSev  per-severity enable.
- `esc_map_i`  in  NEscSev×2  phase index assigned to each severity.
- `phase_cyc_i`  in  4×EscCntDw  cycle threshold per phase.
- `esc_trig_o`  out  1  one-cycle pulse when escalation starts.
- `esc_sig_req_o`  out  NEscSev  escalation requests.
- `latch_crashdump_o`  out  1  one-cycle crashdump latch pulse.
- `esc_cnt_o`  out  EscCntDw  current counter value.
- `esc_state_o`  out  3  current state, `cstate_e`.

## Operation
- States/encoding: Idle=0, Timeout=1, FsmError=2, Terminal=3, Phase0..Phase3=4..7.
- `start` = `en_i & accu_trig_i`.
- Idle: cnt=0. `start` → Phase0. Else `en_i & timeout_en_i & timeout_cyc_i!=0` → Timeout, with cnt cleared.
- Timeout:
  - `start`, or cnt+1 ≥ `timeout_cyc_i` → Phase0, with cnt cleared.
  - `!timeout_en_i` → Idle.
  - Otherwise cnt increments.
- PhaseK: cnt < `phase_cyc_i[K]` → cnt increments. Else → Phase(K+1), or Terminal from Phase3, with cnt cleared. `clr_i` → Idle.
- Terminal: hold, cnt=0. `clr_i` → Idle.
- `accu_fail_i` from any state → FsmError. FsmError is absorbing, ignores `clr_i` and exits only via reset.
- `clr_i` in Idle/Timeout → Idle, with cnt cleared. In Timeout, `clr_i` has priority over `start`. In PhaseK, `clr_i` has priority over advance.
- Priority: `accu_fail_i` > `clr_i` > `start` > counter/threshold conditions.
- `esc_trig_o`: high in the cycle in which the next state is Phase0 and the current state is Idle or Timeout.
- `latch_crashdump_o`: high in the cycle in which the next state is Phase`crashdump_phase_i` and the current state differs.
- `esc_sig_req_o[s]`: in PhaseK, equals `esc_en_i[s] & (esc_map_i[s]==K)`. In FsmError, all bits are 1. Otherwise 0.
- Counter: saturates at all-ones and never wraps. All comparisons are unsigned, full EscCntDw width.
- Threshold inputs are sampled live, not latched at escalation start.

## Timing
- Reset values: state Idle, cnt 0. All outputs 0, except `esc_state_o`=0 (Idle).
- State and cnt are registered. `esc_sig_req_o` and `esc_state_o` decode from registered state only (Moore, no combinational input path except FsmError entry the next cycle).
- `esc_trig_o` and `latch_crashdump_o` are combinational from state and inputs, single-cycle.
- Phase dwell time = `phase_cyc_i[K]`+1 cycles.
- Timeout from arm to Phase0 = `timeout_cyc_i` cycles.
- Reset mid-escalation: return to Idle asynchronously. Outputs are 0 on the same edge.

## Structure
- `alert_pkg` gets:
  - `cstate_e` (3-bit encoding above)
  - `N_PHASES=4`
  - `PhaseDw=2`
  - `EscCntDw` default
- One sub-module, `alert_handler_esc_cnt`: saturating EscCntDw counter with clear and increment inputs, reset to 0. It is instantiated once.
- Assertions:
  - `!en_i` in Idle implies `!esc_trig_o`.
  - FsmError is sticky.
  - `esc_sig_req_o` is one-hot-per-phase consistent with `esc_map_i`.

## Test plan
- `en_i`=1, pulse `accu_trig_i`; `phase_cyc_i`={2,3,0,1}; map severities 0..3 to phases 0..3, all enabled. Required response:
  - `esc_trig_o` one cycle.
  - Each severity is high for 3, 4, 1 and 2 cycles respectively.
  - Terminal is then reached with all requests 0.
- `timeout_cyc_i`=5, `timeout_en_i` held. Required response: Phase0 is entered exactly 5 cycles after arming. Dropping `timeout_en_i` at cycle 3 instead returns to Idle with cnt 0.
- `clr_i` asserted in Phase2 at the same cycle as advance → Idle next cycle, no Phase3 request. `clr_i` in Terminal → Idle.
- `accu_fail_i` pulsed in Phase1 → FsmError with all `esc_sig_req_o`=1. A subsequent `clr_i` has no effect. Only `rst_i` returns the block to Idle.
- `crashdump_phase_i`=2 → `latch_crashdump_o` is a single pulse on the Phase1→Phase2 transition only.
- `phase_cyc_i[0]`=all-ones with EscCntDw=8 → cnt saturates at 255 and advances to Phase1 without wrap.
